// File: rtl/alu_issue_decoder.sv
// RV32I ALU-issue decoder: decodes one instruction per cycle into an ALU control
// bundle and delivers it through a 2-entry skid buffer (output register + skid).
module alu_issue_decoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] imm,
  output logic             use_imm,
  output logic             is_branch,
  output logic             take_if_zero,
  output logic             is_jump,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] imm;
    logic             use_imm;
    logic             is_branch;
    logic             take_if_zero;
    logic             is_jump;
    logic             illegal;
  } bundle_t;

  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_shamt;
  logic             legal;
  bundle_t          dec;

  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s     = {{(WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{(WIDTH-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_shamt = {{(WIDTH-5){1'b0}}, instr[24:20]};

  always_comb begin
    // NOTE: every field gets a default before the case so no path infers a latch.
    dec   = '0;
    legal = 1'b1;
    // All legal opcodes end in 2'b11, so the opcode match also rejects instr[1:0] != 11.
    case (instr[6:0])
      OPC_OP: begin
        dec.alu_control = {instr[30], funct3};
        legal = (funct7 == F7_ZERO) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.use_imm     = 1'b1;
        dec.alu_control = {(funct3 == 3'b101) && instr[30], funct3};
        dec.imm         = imm_i;
        if (funct3 == 3'b001) begin
          dec.imm = imm_shamt;
          legal   = (funct7 == F7_ZERO);
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_shamt;
          legal   = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        end
      end
      OPC_BRANCH: begin
        dec.is_branch    = 1'b1;
        dec.imm          = imm_b;
        dec.take_if_zero = 1'b1;
        case (funct3)
          3'b000: dec.alu_control = 4'b1000;
          3'b001: begin
            dec.alu_control  = 4'b1000;
            dec.take_if_zero = 1'b0;
          end
          3'b100: dec.alu_control = 4'b0010;
          3'b101: dec.alu_control = 4'b1010;
          3'b110: dec.alu_control = 4'b0011;
          3'b111: dec.alu_control = 4'b1011;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
      end
      OPC_STORE: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
      end
      OPC_JALR: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec.is_jump = 1'b1;
        legal       = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  logic    accept, out_free;
  logic    skid_valid, skid_valid_d, out_valid_d;
  bundle_t out_q, out_d, skid_q, skid_d;

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_comb begin
    out_valid_d  = out_valid;
    out_d        = out_q;
    skid_valid_d = skid_valid;
    skid_d       = skid_q;
    if (out_free) begin
      if (skid_valid) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = dec;
    end
  end

  // Data registers are reset too: all output fields must read 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      in_ready   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates race-free on the edge.
      out_valid  <= out_valid_d;
      out_q      <= out_d;
      skid_valid <= skid_valid_d;
      skid_q     <= skid_d;
      in_ready   <= !skid_valid_d;
    end
  end

  assign alu_control  = out_q.alu_control;
  assign imm          = out_q.imm;
  assign use_imm      = out_q.use_imm;
  assign is_branch    = out_q.is_branch;
  assign take_if_zero = out_q.take_if_zero;
  assign is_jump      = out_q.is_jump;
  assign illegal      = out_q.illegal;

endmodule
